// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// One operation in flight: accept (IDLE) -> execute (EXEC) -> respond (RESP).
module alu_arbiter #(
  parameter int DataWidth = 16,
  parameter int OpWidth   = 5
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic [1:0]           ReqValid,
  output logic [1:0]           ReqReady,
  input  logic [OpWidth-1:0]   ReqOpcode0,
  input  logic [OpWidth-1:0]   ReqOpcode1,
  input  logic [DataWidth-1:0] ReqOperandA0,
  input  logic [DataWidth-1:0] ReqOperandA1,
  input  logic [DataWidth-1:0] ReqOperandB0,
  input  logic [DataWidth-1:0] ReqOperandB1,
  output logic [OpWidth-1:0]   AluOpcode,
  output logic [DataWidth-1:0] AluOperandA,
  output logic [DataWidth-1:0] AluOperandB,
  input  logic [DataWidth-1:0] AluResult,
  input  logic                 AluCarry,
  input  logic                 AluNegative,
  input  logic                 AluOverflow,
  output logic                 RespValid,
  input  logic                 RespReady,
  output logic                 RespId,
  output logic [DataWidth-1:0] RespResult,
  output logic                 RespCarry,
  output logic                 RespNegative,
  output logic                 RespOverflow
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state, state_next;
  logic   last_grant;
  logic   grant_valid;
  logic   grant_id;
  logic   handshake;

  // NOTE: sequential state is always written with <= so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge Clock) begin
    if (Reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (handshake) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (RespValid && RespReady) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = 1'b0;
    ReqReady    = 2'b00;
    if (state == IDLE && !Reset) begin
      case (ReqValid)
        2'b11: begin grant_valid = 1'b1; grant_id = ~last_grant; end
        2'b01: begin grant_valid = 1'b1; grant_id = 1'b0;        end
        2'b10: begin grant_valid = 1'b1; grant_id = 1'b1;        end
        default: ;
      endcase
      if (grant_valid) ReqReady = grant_id ? 2'b10 : 2'b01;
    end
  end

  assign handshake = |(ReqValid & ReqReady);

  // Operand registers only load on a handshake; they keep their last value
  // otherwise so the ALU inputs do not toggle between operations.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      last_grant   <= 1'b1;
      AluOpcode    <= '0;
      AluOperandA  <= '0;
      AluOperandB  <= '0;
      RespValid    <= 1'b0;
      RespId       <= 1'b0;
      RespResult   <= '0;
      RespCarry    <= 1'b0;
      RespNegative <= 1'b0;
      RespOverflow <= 1'b0;
    end else begin
      if (handshake) begin
        last_grant  <= grant_id;
        RespId      <= grant_id;
        AluOpcode   <= grant_id ? ReqOpcode1   : ReqOpcode0;
        AluOperandA <= grant_id ? ReqOperandA1 : ReqOperandA0;
        AluOperandB <= grant_id ? ReqOperandB1 : ReqOperandB0;
      end
      if (state == EXEC) begin
        RespResult   <= AluResult;
        RespCarry    <= AluCarry;
        RespNegative <= AluNegative;
        RespOverflow <= AluOverflow;
        RespValid    <= 1'b1;
      end else if (state == RESP && RespValid && RespReady) begin
        RespValid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: transaction-timeline model compared every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_alu_arbiter;

  localparam int DW = 16;
  localparam int OW = 5;
  localparam logic [OW-1:0] OP_ADD = 5'd0;
  localparam logic [OW-1:0] OP_AND = 5'd1;
  localparam logic [OW-1:0] OP_OR  = 5'd2;

  logic          Clock = 1'b0;
  logic          Reset;
  logic [1:0]    ReqValid;
  logic [1:0]    ReqReady;
  logic [OW-1:0] ReqOpcode0, ReqOpcode1;
  logic [DW-1:0] ReqOperandA0, ReqOperandA1, ReqOperandB0, ReqOperandB1;
  logic [OW-1:0] AluOpcode;
  logic [DW-1:0] AluOperandA, AluOperandB, AluResult;
  logic          AluCarry, AluNegative, AluOverflow;
  logic          RespValid, RespReady, RespId;
  logic [DW-1:0] RespResult;
  logic          RespCarry, RespNegative, RespOverflow;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [DW-1:0] res;
    logic          c;
    logic          n;
    logic          v;
  } alu_out_t;

  // Bench ALU: ADD / AND / OR, anything else XOR.
  function automatic alu_out_t alu_fn(input logic [OW-1:0] op, input logic [DW-1:0] a,
                                      input logic [DW-1:0] b);
    alu_out_t   o;
    logic [DW:0] s;
    o = '0;
    case (op)
      OP_ADD: begin
        s     = {1'b0, a} + {1'b0, b};
        o.res = s[DW-1:0];
        o.c   = s[DW];
        o.v   = (a[DW-1] == b[DW-1]) && (o.res[DW-1] != a[DW-1]);
      end
      OP_AND:  o.res = a & b;
      OP_OR:   o.res = a | b;
      default: o.res = a ^ b;
    endcase
    o.n = o.res[DW-1];
    return o;
  endfunction

  assign {AluResult, AluCarry, AluNegative, AluOverflow} = alu_fn(AluOpcode, AluOperandA, AluOperandB);

  alu_arbiter #(.DataWidth(DW), .OpWidth(OW)) dut (
    .Clock(Clock), .Reset(Reset),
    .ReqValid(ReqValid), .ReqReady(ReqReady),
    .ReqOpcode0(ReqOpcode0), .ReqOpcode1(ReqOpcode1),
    .ReqOperandA0(ReqOperandA0), .ReqOperandA1(ReqOperandA1),
    .ReqOperandB0(ReqOperandB0), .ReqOperandB1(ReqOperandB1),
    .AluOpcode(AluOpcode), .AluOperandA(AluOperandA), .AluOperandB(AluOperandB),
    .AluResult(AluResult), .AluCarry(AluCarry), .AluNegative(AluNegative),
    .AluOverflow(AluOverflow),
    .RespValid(RespValid), .RespReady(RespReady), .RespId(RespId),
    .RespResult(RespResult), .RespCarry(RespCarry), .RespNegative(RespNegative),
    .RespOverflow(RespOverflow)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: age of the operation in flight (0 none, 1 just accepted, 2 response held).
  bit            armed = 1'b0;
  int            m_age;
  logic          m_last, m_id, m_rv;
  logic [OW-1:0] m_op;
  logic [DW-1:0] m_a, m_b;
  alu_out_t      m_resp;

  function automatic logic [1:0] model_ready();
    if (Reset || m_age != 0) return 2'b00;
    if (ReqValid == 2'b11)   return m_last ? 2'b01 : 2'b10;
    return ReqValid;
  endfunction

  always @(posedge Clock) begin
    logic [1:0] rdy;
    rdy = model_ready();
    armed = 1'b1;
    if (Reset) begin
      m_age = 0; m_last = 1'b1; m_id = 1'b0; m_rv = 1'b0;
      m_op = '0; m_a = '0; m_b = '0; m_resp = '0;
    end else if (m_age == 0) begin
      if (|(ReqValid & rdy)) begin
        m_id   = rdy[1];
        m_last = rdy[1];
        m_op   = rdy[1] ? ReqOpcode1   : ReqOpcode0;
        m_a    = rdy[1] ? ReqOperandA1 : ReqOperandA0;
        m_b    = rdy[1] ? ReqOperandB1 : ReqOperandB0;
        m_age  = 1;
      end
    end else if (m_age == 1) begin
      m_resp = alu_fn(m_op, m_a, m_b);
      m_rv   = 1'b1;
      m_age  = 2;
    end else if (RespReady) begin
      m_rv  = 1'b0;
      m_age = 0;
    end
  end

  always @(negedge Clock) begin
    if (armed) begin
      check("cmp_req_ready", ReqReady, model_ready());
      check("cmp_alu_opcode", AluOpcode, m_op);
      check("cmp_alu_a", AluOperandA, m_a);
      check("cmp_alu_b", AluOperandB, m_b);
      check("cmp_resp_valid", RespValid, m_rv);
      check("cmp_resp_id", RespId, m_id);
      check("cmp_resp_result", RespResult, m_resp.res);
      check("cmp_resp_flags", {RespCarry, RespNegative, RespOverflow}, {m_resp.c, m_resp.n, m_resp.v});
    end
  end

  logic          id_q[$];
  logic [DW-1:0] res_q[$];
  logic [2:0]    flg_q[$];
  logic [1:0]    first_ready;

  // Runs requesters until n responses are collected; one_shot drops a bit once granted.
  task automatic serve(input int n, input bit one_shot, input int budget);
    int         got;
    logic [1:0] granted;
    got = 0;
    first_ready = 2'b00;
    for (int cyc = 0; cyc < budget && got < n; cyc++) begin
      @(negedge Clock);
      if (RespValid && RespReady) begin
        id_q.push_back(RespId);
        res_q.push_back(RespResult);
        flg_q.push_back({RespCarry, RespNegative, RespOverflow});
        got++;
      end
      granted = ReqReady;
      if (first_ready == 2'b00) first_ready = granted;
      check("ready_not_both", {31'd0, granted == 2'b11}, 32'd0);
      @(posedge Clock); #1;
      if (one_shot) ReqValid = ReqValid & ~granted;
    end
    if (got != n) check("serve_timeout", got, n);
    ReqValid = 2'b00;
  endtask

  task automatic wait_resp_valid(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge Clock);
      if (RespValid) seen = 1'b1;
      else begin @(posedge Clock); #1; end
    end
    if (!seen) check(name, 32'd0, 32'd1);
  endtask

  initial begin
    logic [DW-1:0] snap_res;
    logic          snap_id;
    logic [2:0]    snap_flg;

    Reset = 1'b1; ReqValid = 2'b00; RespReady = 1'b0;
    ReqOpcode0 = '0; ReqOpcode1 = '0;
    ReqOperandA0 = '0; ReqOperandA1 = '0; ReqOperandB0 = '0; ReqOperandB1 = '0;
    @(posedge Clock); @(posedge Clock); #1;
    Reset = 1'b0;
    @(negedge Clock);
    check("rst_resp_valid", RespValid, 0);
    check("rst_req_ready", ReqReady, 0);
    check("rst_resp_result", RespResult, 0);

    // Single AND request from requester 0.
    @(posedge Clock); #1;
    ReqOpcode0 = OP_AND; ReqOperandA0 = 16'h00FF; ReqOperandB0 = 16'h0F0F;
    ReqValid = 2'b01; RespReady = 1'b1;
    @(negedge Clock);
    check("single_ready", ReqReady, 2'b01);
    @(posedge Clock); #1; ReqValid = 2'b00;
    @(negedge Clock);
    check("single_ready_once", ReqReady, 2'b00);
    check("single_exec_novalid", RespValid, 0);
    @(posedge Clock); #1;
    @(negedge Clock);
    check("single_valid", RespValid, 1);
    check("single_id", RespId, 0);
    check("single_result", RespResult, 16'h000F);
    @(posedge Clock); #1;
    @(negedge Clock);
    check("single_valid_1cycle", RespValid, 0);

    // Contention right after reset.
    @(posedge Clock); #1; Reset = 1'b1;
    @(posedge Clock); #1; Reset = 1'b0;
    ReqOpcode0 = OP_ADD; ReqOperandA0 = 16'h0001; ReqOperandB0 = 16'h0002;
    ReqOpcode1 = OP_ADD; ReqOperandA1 = 16'h8000; ReqOperandB1 = 16'h8000;
    ReqValid = 2'b11;
    serve(2, 1'b1, 30);
    if (id_q.size() == 2) begin
      check("cont_first_grant", first_ready, 2'b01);
      check("cont_id0", id_q[0], 0);
      check("cont_res0", res_q[0], 16'h0003);
      check("cont_flg0", flg_q[0], 3'b000);
      check("cont_id1", id_q[1], 1);
      check("cont_res1", res_q[1], 16'h0000);
      check("cont_flg1", flg_q[1], 3'b101);
    end
    id_q.delete(); res_q.delete(); flg_q.delete();

    // Fairness: both valid for six operations.
    ReqValid = 2'b11;
    serve(6, 1'b0, 60);
    for (int i = 0; i < id_q.size(); i++) check("fair_id", id_q[i], i % 2);
    id_q.delete(); res_q.delete(); flg_q.delete();

    // Backpressure on requester 1's AND, then requester 0's OR (flag passthrough).
    RespReady = 1'b0;
    ReqOpcode1 = OP_AND; ReqOperandA1 = 16'h1234; ReqOperandB1 = 16'hFF00;
    ReqOpcode0 = OP_OR;  ReqOperandA0 = 16'hFFFF; ReqOperandB0 = 16'h0000;
    ReqValid = 2'b10;
    @(negedge Clock);
    check("bp_grant", ReqReady, 2'b10);
    @(posedge Clock); #1; ReqValid = 2'b01;
    wait_resp_valid("bp_wait_timeout");
    check("bp_result", RespResult, 16'h1200);
    check("bp_id", RespId, 1);
    snap_res = RespResult; snap_id = RespId;
    snap_flg = {RespCarry, RespNegative, RespOverflow};
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin @(posedge Clock); #1; @(negedge Clock); end
      check("bp_hold_valid", RespValid, 1);
      check("bp_hold_result", RespResult, snap_res);
      check("bp_hold_id", RespId, snap_id);
      check("bp_hold_flags", {RespCarry, RespNegative, RespOverflow}, snap_flg);
      check("bp_no_grant", ReqReady, 2'b00);
    end
    @(posedge Clock); #1; RespReady = 1'b1;
    @(negedge Clock);
    check("bp_release_valid", RespValid, 1);
    check("bp_release_no_grant", ReqReady, 2'b00);
    @(posedge Clock); #1;
    @(negedge Clock);
    check("bp_idle_valid", RespValid, 0);
    check("bp_idle_grant", ReqReady, 2'b01);
    @(posedge Clock); #1; ReqValid = 2'b00;
    wait_resp_valid("flag_wait_timeout");
    check("flag_result", RespResult, 16'hFFFF);
    check("flag_neg", RespNegative, 1);
    check("flag_carry", RespCarry, 0);
    check("flag_id", RespId, 0);
    @(posedge Clock); #1;

    // Reset while in EXEC aborts the operation.
    ReqOpcode1 = OP_ADD; ReqOperandA1 = 16'h7FFF; ReqOperandB1 = 16'h0001;
    ReqValid = 2'b10;
    @(negedge Clock);
    check("abort_grant", ReqReady, 2'b10);
    @(posedge Clock); #1; ReqValid = 2'b00; Reset = 1'b1;
    @(posedge Clock); #1; Reset = 1'b0;
    @(negedge Clock);
    check("abort_alu_op", AluOpcode, 0);
    check("abort_alu_a", AluOperandA, 0);
    check("abort_alu_b", AluOperandB, 0);
    check("abort_resp", {RespValid, RespId, RespCarry, RespNegative, RespOverflow}, 0);
    check("abort_result", RespResult, 0);
    for (int i = 0; i < 4; i++) begin
      @(posedge Clock); #1; @(negedge Clock);
      check("abort_no_resp", RespValid, 0);
    end
    @(posedge Clock); #1;
    ReqOpcode0 = OP_ADD; ReqOperandA0 = 16'h0005; ReqOperandB0 = 16'h0006;
    ReqOpcode1 = OP_AND; ReqOperandA1 = 16'hF0F0; ReqOperandB1 = 16'h3C3C;
    ReqValid = 2'b11;
    serve(2, 1'b1, 30);
    if (id_q.size() == 2) begin
      check("post_abort_first_grant", first_ready, 2'b01);
      check("post_abort_id0", id_q[0], 0);
      check("post_abort_res0", res_q[0], 16'h000B);
      check("post_abort_id1", id_q[1], 1);
      check("post_abort_res1", res_q[1], 16'h3030);
    end

    repeat (3) @(posedge Clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one combinational 16-bit `alu` instance between two requesters, such as the execute stage and the address/branch unit. The block grants requesters round-robin, registers the winning opcode and operands, and drives them onto the ALU. It then captures the ALU result and flags and returns them on a tagged valid/ready response port. One operation is in flight at a time. Minimum occupancy is 3 cycles per operation.

## Interface
Parameters:
- DataWidth, 16, operand/result width; must match the attached `alu`
- OpWidth, 5, opcode width; must match `alu` Opcode

Ports:
- Clock  input  1  rising-edge clock; the only clock
- Reset  input  1  synchronous, active-high reset
- ReqValid  input  2  bit i: requester i presents an operation
- ReqReady  output  2  bit i: requester i accepted this cycle (at most one bit high)
- ReqOpcode0, ReqOpcode1  input  OpWidth  opcode per requester
- ReqOperandA0, ReqOperandA1  input  DataWidth  operand A per requester
- ReqOperandB0, ReqOperandB1  input  DataWidth  operand B per requester
- AluOpcode  output  OpWidth  to `alu` Opcode (registered)
- AluOperandA  output  DataWidth  to `alu` OperandA (registered)
- AluOperandB  output  DataWidth  to `alu` OperandB (registered)
- AluResult  input  DataWidth  from `alu` Result
- AluCarry, AluNegative, AluOverflow  input  1  from `alu` flags
- RespValid  output  1  response available
- RespReady  input  1  consumer accepts response
- RespId  output  1  requester index the response belongs to
- RespResult  output  DataWidth  captured result
- RespCarry, RespNegative, RespOverflow  output  1  captured flags

## Operation
- The state machine has three states: IDLE, EXEC and RESP.
- **IDLE**
  - Grant target: if both ReqValid bits are high, grant the requester != LastGrant. If exactly one is high, grant that one. If none is high, grant nothing.
  - ReqReady[g] is combinational and high only for the grant target in IDLE. It is 0 in every other state and whenever Reset=1.
  - On handshake (ReqValid[g] & ReqReady[g]): register that requester's opcode and operands into AluOpcode/AluOperandA/AluOperandB, set LastGrant←g and set RespId←g. Go to EXEC.
- **EXEC**
  - The registered Alu* outputs are stable for the whole cycle.
  - At the clock edge, capture AluResult and the three flags into the Resp* registers, set RespValid←1 and go to RESP.
- **RESP**
  - All Resp* outputs are held stable while RespValid=1 and RespReady=0.
  - When RespValid & RespReady: RespValid←0 and go to IDLE.
  - No new grant is issued in the same cycle as a response handshake.
- Alu* outputs hold their last values outside of a handshake. They are not cleared after an operation.
- The block does not interpret the opcode; the result and flags pass through bit-exact.
- Requesters must hold Req* inputs stable while ReqValid is high and not yet accepted. The block samples them only on the handshake cycle.

## Timing
- Reset values: state=IDLE, LastGrant=1 (so requester 0 wins the first contention), RespValid=0, RespId=0, RespResult=0, all Resp flags=0, AluOpcode=0, AluOperandA=0, AluOperandB=0.
- Request handshake at edge N → Alu* outputs valid after N → result captured at edge N+1 → RespValid=1 after N+1.
- Best-case throughput with RespReady tied high is one operation per 3 cycles: accept, exec, resp.
- Simultaneous requests: grants strictly alternate 0,1,0,1… while both requesters stay valid.
- A requester dropping ReqValid before its grant is legal and has no side effect.
- Reset asserted in any state aborts the operation: no response is produced and all registers return to their reset values on that edge. The first grant after reset follows the LastGrant=1 rule.
- RespReady high while RespValid=0 has no effect.

## Test plan
- Single request, with the bench `alu` model doing AND: requester 0 sends A=0x00FF, B=0x0F0F. Required response: ReqReady=2'b01 for exactly one cycle, RespValid rises 2 cycles later with RespId=0 and RespResult=0x000F; with RespReady=1, RespValid lasts one cycle.
- Contention right after reset: both requesters valid (0: A=0x0001 B=0x0002, 1: A=0x8000 B=0x8000, ADD model). Required: responses in order id 0 (0x0003, C=0) then id 1 (0x0000, Carry=1, Overflow=1).
- Fairness: both requesters valid continuously for 6 operations. Required: RespId sequence 0,1,0,1,0,1, and ReqReady is never 2'b11.
- Backpressure: RespReady=0 for 5 cycles after RespValid rises. Required: RespResult, RespId and flags stay constant, ReqReady stays 0, and IDLE is re-entered the cycle after RespReady=1.
- Reset mid-EXEC: assert Reset for one cycle in EXEC. Required: RespValid is never asserted for that operation, all outputs are 0, and the next contention grants requester 0.
- Flag passthrough: bench model returns Result=0xFFFF with Negative=1 and Carry=0. Required: RespNegative=1, RespCarry=0, RespResult=0xFFFF.
